// File: rtl/dll_tx_arb.sv
// Data link layer transmit arbiter.
// Merges a TLP beat stream with DLLPs from several sources onto a PIPE TX
// interface through a single output register. TLPs are never interrupted
// mid-packet. All pending DLLPs are packed into one beat. A bounded DLLP
// streak counter keeps TLPs moving when both kinds of traffic are waiting.
module dll_tx_arb #(
    parameter int PIPE_DATA_WIDTH = 256,
    parameter int DLLP_WIDTH      = 64,
    parameter int DLLP_SRC_CNT    = 3,
    parameter int DLLP_BURST_MAX  = 4
) (
    input  logic                               sclk,
    input  logic                               srst,
    input  logic                               link_up_i,
    input  logic                               tlp_valid_i,
    input  logic [PIPE_DATA_WIDTH-1:0]         tlp_data_i,
    input  logic                               tlp_last_i,
    output logic                               tlp_ready_o,
    input  logic [DLLP_SRC_CNT-1:0]            dllp_valid_i,
    input  logic [DLLP_SRC_CNT*DLLP_WIDTH-1:0] dllp_data_i,
    output logic [DLLP_SRC_CNT-1:0]            dllp_ready_o,
    output logic [PIPE_DATA_WIDTH-1:0]         pipe_txdata_o,
    output logic                               pipe_txvalid_o,
    output logic                               pipe_txdllp_o,
    input  logic                               pipe_txready_i
);

    localparam logic [7:0] BURST_LIMIT = 8'(DLLP_BURST_MAX);

    typedef enum logic {
        ST_BOUNDARY,
        ST_IN_TLP
    } state_e;

    state_e                     state_q, state_d;
    logic [7:0]                 streak_q, streak_d;
    logic [PIPE_DATA_WIDTH-1:0] txdata_q, txdata_d;
    logic                       txvalid_q, txvalid_d;
    logic                       txdllp_q, txdllp_d;

    logic                       ld;
    logic                       tlp_ok;
    logic                       dllp_any;
    logic                       grant_tlp;
    logic                       grant_dllp;
    logic [PIPE_DATA_WIDTH-1:0] dllp_packed;

    // Pack every pending DLLP into consecutive slots, lowest source index first.
    always_comb begin
        int slot;
        // NOTE: every always_comb output gets a default before any branch, so no
        // path leaves it unassigned and no latch is inferred.
        dllp_packed = '0;
        slot        = 0;
        for (int i = 0; i < DLLP_SRC_CNT; i++) begin
            if (dllp_valid_i[i]) begin
                dllp_packed[slot*DLLP_WIDTH +: DLLP_WIDTH] = dllp_data_i[i*DLLP_WIDTH +: DLLP_WIDTH];
                slot = slot + 1;
            end
        end
    end

    // Arbitration and next-state: DLLPs only between packets, capped by the streak.
    always_comb begin
        ld         = !txvalid_q || pipe_txready_i;
        tlp_ok     = tlp_valid_i && link_up_i;
        dllp_any   = |dllp_valid_i;
        grant_tlp  = 1'b0;
        grant_dllp = 1'b0;
        state_d    = state_q;

        case (state_q)
            ST_BOUNDARY: begin
                if (dllp_any && !(tlp_ok && (streak_q >= BURST_LIMIT))) begin
                    grant_dllp = 1'b1;
                end else if (tlp_ok) begin
                    grant_tlp = 1'b1;
                end
            end
            ST_IN_TLP: begin
                // Mid-packet: link state is ignored so the packet always completes.
                grant_tlp = tlp_valid_i;
            end
            default: ;
        endcase

        if (ld && grant_tlp) begin
            state_d = tlp_last_i ? ST_BOUNDARY : ST_IN_TLP;
        end
    end

    // Handshakes are only offered when the output register can take a beat.
    always_comb begin
        tlp_ready_o  = ld && grant_tlp && !srst;
        dllp_ready_o = (ld && grant_dllp && !srst) ? dllp_valid_i : '0;
    end

    // Output register next value and DLLP streak bookkeeping.
    always_comb begin
        txdata_d  = txdata_q;
        txvalid_d = txvalid_q;
        txdllp_d  = txdllp_q;
        streak_d  = streak_q;

        if (ld) begin
            txvalid_d = grant_tlp || grant_dllp;
            if (grant_tlp) begin
                txdata_d = tlp_data_i;
                txdllp_d = 1'b0;
                streak_d = '0;
            end else if (grant_dllp) begin
                txdata_d = dllp_packed;
                txdllp_d = 1'b1;
                // Only DLLPs that actually delay a waiting TLP count toward the cap.
                if (tlp_ok && (streak_q < BURST_LIMIT)) begin
                    streak_d = streak_q + 8'd1;
                end
            end
        end
    end

    // State, streak and output registers with synchronous reset.
    always_ff @(posedge sclk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (srst) begin
            state_q   <= ST_BOUNDARY;
            streak_q  <= '0;
            txdata_q  <= '0;
            txvalid_q <= 1'b0;
            txdllp_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            streak_q  <= streak_d;
            txdata_q  <= txdata_d;
            txvalid_q <= txvalid_d;
            txdllp_q  <= txdllp_d;
        end
    end

    assign pipe_txdata_o  = txdata_q;
    assign pipe_txvalid_o = txvalid_q;
    assign pipe_txdllp_o  = txdllp_q;

endmodule

// File: doc/dll_tx_arb.md
Name: dll_tx_arb

Overview:
Parametrised transmit-side arbiter for the data link layer. It merges the TLP stream from the retry/write path with DLLPs from several sources (Ack/Nak, UpdateFC, InitFC, etc.) onto the PIPE TX interface. TLPs are never interleaved mid-packet. Pending DLLPs are packed several per beat. Bounded DLLP priority guarantees TLP forward progress. It replaces the fixed single-DLLP-source arbitration in the link-layer top with a generic N-source, width-scalable block that honours PIPE backpressure.

Parameters:
PIPE_DATA_WIDTH, 256, TX beat width in bits; must be a multiple of DLLP_WIDTH.
DLLP_WIDTH, 64, bits per DLLP slot (6-byte DLLP plus 2-byte CRC/framing).
DLLP_SRC_CNT, 3, number of DLLP sources; must be <= PIPE_DATA_WIDTH/DLLP_WIDTH.
DLLP_BURST_MAX, 4, max consecutive DLLP beats while a TLP is eligible; range 1..255.

Ports:
sclk  in  1  clock
srst  in  1  synchronous reset, active-high
link_up_i  in  1  DL_Active; when 0, no new TLP may start
tlp_valid_i  in  1  TLP beat valid
tlp_data_i  in  PIPE_DATA_WIDTH  TLP beat
tlp_last_i  in  1  final beat of TLP
tlp_ready_o  out  1  TLP beat accepted this cycle
dllp_valid_i  in  DLLP_SRC_CNT  per-source DLLP pending
dllp_data_i  in  DLLP_SRC_CNT*DLLP_WIDTH  source i at [i*DLLP_WIDTH +: DLLP_WIDTH]
dllp_ready_o  out  DLLP_SRC_CNT  per-source DLLP accepted
pipe_txdata_o  out  PIPE_DATA_WIDTH  TX beat
pipe_txvalid_o  out  1  TX beat valid
pipe_txdllp_o  out  1  1 = beat carries DLLPs, 0 = TLP
pipe_txready_i  in  1  PIPE accepts beat

Behaviour:
- Output stage: a single register. ld = !pipe_txvalid_o || pipe_txready_i. New beat loaded only when ld=1. When ld=0, data, valid and type are held stable and all ready_o are 0.
- Latency: input accepted in cycle N appears on pipe_* in cycle N+1.
- Ready signals are combinational:
  - tlp_ready_o = ld & grant_tlp
  - dllp_ready_o[i] = ld & grant_dllp & dllp_valid_i[i]
- FSM states:
  - BOUNDARY (reset): between packets. Let tlp_ok = tlp_valid_i & link_up_i and dllp_any = |dllp_valid_i.
    - If dllp_any and !(tlp_ok & streak >= DLLP_BURST_MAX): grant_dllp.
    - Else if tlp_ok: grant_tlp; go to IN_TLP if !tlp_last_i, else stay.
    - Else: no grant; when ld=1, load pipe_txvalid_o=0.
  - IN_TLP: only TLP may be granted (grant_tlp = tlp_valid_i). Return to BOUNDARY on an accepted beat with tlp_last_i=1.
    - tlp_valid_i=0 produces a bubble (valid 0). No DLLP insertion.
    - link_up_i is ignored mid-packet; the packet completes.
- DLLP packing: every valid source is taken in the same beat. Sources are placed in ascending index order into consecutive slots starting at slot 0 (slot k = bits [k*DLLP_WIDTH +: DLLP_WIDTH]). Unused slots are zero. pipe_txdllp_o=1.
- streak counter (8-bit, saturating at DLLP_BURST_MAX):
  - +1 on a DLLP beat loaded while tlp_ok=1.
  - Cleared on any TLP beat loaded.
  - Unchanged on a DLLP beat loaded while tlp_ok=0.
- TLP beat: pipe_txdata_o = tlp_data_i, pipe_txdllp_o=0.
- Reset (srst=1, synchronous): pipe_txvalid_o=0, pipe_txdata_o=0, pipe_txdllp_o=0, state=BOUNDARY, streak=0. Ready outputs are 0 during reset.
- Reset mid-TLP: the partial packet is abandoned. The upstream retry logic is reset by the same srst.
- Simultaneous TLP start and DLLP pending with streak < limit: DLLP wins.
- A source deasserting valid before ready is outside the protocol; sources hold valid until ready.

Test Plan:
1. Reset: assert srst 2 cycles with random inputs -> pipe_txvalid_o=0, pipe_txdata_o=0, tlp_ready_o=0, dllp_ready_o=0; first beat appears 1 cycle after the first grant.
2. Defer DLLP: 3-beat TLP (A,B,C); dllp_valid_i[0] rises during beat A -> output sequence A,B,C,D0 with txdllp=0,0,0,1; dllp_ready_o[0] pulses only in the cycle C's successor loads.
3. Packing (256/64, 3 sources): all three valid with data 0x11..,0x22..,0x33.. -> single beat, slots0..2 = src0..2, slot3=0, dllp_ready_o=3'b111 in the same cycle.
4. Starvation bound (DLLP_BURST_MAX=2): src0 always valid, continuous single-beat TLPs, link up -> pattern D,D,T,D,D,T, streak cleared after each T.
5. Backpressure: pipe_txready_i=0 for 3 cycles while a TLP beat is valid -> pipe_txdata_o stable, tlp_ready_o=0 and dllp_ready_o=0; the next beat follows 1 cycle after ready returns, with no loss or duplication.
6. Link down: link_up_i=0 with TLP valid, src1 valid -> DLLP beats only, tlp_ready_o stays 0. Drop link_up_i in the middle of a 4-beat TLP -> all 4 beats still sent.
